// File: rtl/multu_hilo.sv
// Sequential 32x32 unsigned multiplier (MULTU) with the architectural HI/LO pair.
// Radix-2 shift-add, fixed WIDTH+1 cycle latency, plus MTHI/MTLO direct writes.
module multu_hilo #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] dataA,
    input  logic [WIDTH-1:0] dataB,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] HiOut,
    output logic [WIDTH-1:0] LoOut
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FINISH
    } state_t;

    state_t             state;
    state_t             state_next;

    logic [WIDTH-1:0]   mcand;
    logic [2*WIDTH-1:0] prod;
    logic [CW-1:0]      count;

    logic               load;
    logic               step;
    logic               commit;
    logic               wr_hi;
    logic               wr_lo;

    logic [WIDTH:0]     addend;
    logic [WIDTH:0]     upper_sum;
    logic [2*WIDTH-1:0] prod_step;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // MT writes are only honoured in IDLE and only when no multiply is launched.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        step       = 1'b0;
        commit     = 1'b0;
        wr_hi      = 1'b0;
        wr_lo      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = RUN;
                end else begin
                    wr_hi = mthi;
                    wr_lo = mtlo;
                end
            end
            RUN: begin
                step = 1'b1;
                if (count == CW'(WIDTH - 1)) begin
                    state_next = FINISH;
                end
            end
            FINISH: begin
                commit     = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Carry out of the upper-half add is shifted back into the product MSB.
    always_comb begin
        addend    = prod[0] ? {1'b0, mcand} : '0;
        upper_sum = {1'b0, prod[2*WIDTH-1:WIDTH]} + addend;
        prod_step = {upper_sum, prod[WIDTH-1:1]};
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            mcand <= '0;
            prod  <= '0;
            count <= '0;
            HiOut <= '0;
            LoOut <= '0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (load) begin
                mcand <= dataA;
                prod  <= {{WIDTH{1'b0}}, dataB};
                count <= '0;
            end
            if (step) begin
                prod  <= prod_step;
                count <= count + CW'(1);
            end
            if (commit) begin
                HiOut <= prod[2*WIDTH-1:WIDTH];
                LoOut <= prod[WIDTH-1:0];
                done  <= 1'b1;
            end
            if (wr_hi) begin
                HiOut <= dataA;
            end
            if (wr_lo) begin
                LoOut <= dataA;
            end
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_multu_hilo.sv
// Self-checking bench for multu_hilo: scenario tasks plus a done-driven scoreboard.
module tb_multu_hilo;

    logic        clk;
    logic        reset;
    logic        start;
    logic        mthi;
    logic        mtlo;
    logic [31:0] dataA;
    logic [31:0] dataB;
    logic        busy;
    logic        done;
    logic [31:0] HiOut;
    logic [31:0] LoOut;

    int vectors;
    int miscompares;

    logic [63:0] exp_q[$];

    multu_hilo #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .mthi  (mthi),
        .mtlo  (mtlo),
        .dataA (dataA),
        .dataB (dataB),
        .busy  (busy),
        .done  (done),
        .HiOut (HiOut),
        .LoOut (LoOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Every done pulse must match the oldest outstanding product.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            logic [63:0] e;
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL scoreboard_unexpected_done: got HI=%h LO=%h, required no done", HiOut, LoOut);
            end else begin
                e = exp_q.pop_front();
                if ({HiOut, LoOut} !== e) begin
                    miscompares++;
                    $display("FAIL scoreboard_product: got HI=%h LO=%h, required HI=%h LO=%h",
                             HiOut, LoOut, e[63:32], e[31:0]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Launch a multiply, record its product, and return the start-to-done latency (-1 on timeout).
    task automatic run_mul(input logic [31:0] a, input logic [31:0] b, output int lat);
        logic [63:0] p;
        p = {32'b0, a} * {32'b0, b};
        dataA = a;
        dataB = b;
        start = 1'b1;
        exp_q.push_back(p);
        tick();
        start = 1'b0;
        lat = -1;
        for (int k = 0; k < 40; k++) begin
            if (done === 1'b1) begin
                lat = k;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        start = 1'b0;
        mthi  = 1'b0;
        mtlo  = 1'b0;
        dataA = '0;
        dataB = '0;
        tick();
        tick();
        reset = 1'b1;
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0 || HiOut !== '0 || LoOut !== '0) begin
            miscompares++;
            $display("FAIL reset_state: got busy=%b done=%b HI=%h LO=%h, required all zero",
                     busy, done, HiOut, LoOut);
        end
        dataA = 32'h5555_AAAA;
        dataB = 32'h1234_5678;
        for (int k = 0; k < 50; k++) begin
            tick();
            vectors++;
            if (busy !== 1'b0 || done !== 1'b0 || HiOut !== '0 || LoOut !== '0) begin
                miscompares++;
                $display("FAIL idle_quiet cycle %0d: got busy=%b done=%b HI=%h LO=%h, required all zero",
                         k, busy, done, HiOut, LoOut);
            end
        end
    endtask

    task automatic test_basic();
        dataA = 32'd7;
        dataB = 32'd6;
        start = 1'b1;
        exp_q.push_back(64'd42);
        tick();
        start = 1'b0;
        dataA = '0;
        dataB = '0;
        for (int k = 0; k <= 34; k++) begin
            vectors++;
            if (k <= 32) begin
                if (busy !== 1'b1 || done !== 1'b0) begin
                    miscompares++;
                    $display("FAIL basic_busy k=%0d: got busy=%b done=%b, required busy=1 done=0", k, busy, done);
                end
            end else if (k == 33) begin
                if (busy !== 1'b0 || done !== 1'b1) begin
                    miscompares++;
                    $display("FAIL basic_done k=33: got busy=%b done=%b, required busy=0 done=1", busy, done);
                end
            end else begin
                if (busy !== 1'b0 || done !== 1'b0) begin
                    miscompares++;
                    $display("FAIL basic_pulse_end k=34: got busy=%b done=%b, required busy=0 done=0", busy, done);
                end
            end
            if (k == 16) begin
                vectors++;
                if (HiOut !== '0 || LoOut !== '0) begin
                    miscompares++;
                    $display("FAIL basic_hold: got HI=%h LO=%h, required HI=0 LO=0", HiOut, LoOut);
                end
            end
            if (k < 34) tick();
        end
    endtask

    task automatic test_full_width();
        int lat;
        logic [31:0] a;
        logic [31:0] b;
        run_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, lat);
        vectors++;
        if (lat != 33 || HiOut !== 32'hFFFF_FFFE || LoOut !== 32'h0000_0001) begin
            miscompares++;
            $display("FAIL full_ones: got lat=%0d HI=%h LO=%h, required lat=33 HI=fffffffe LO=00000001",
                     lat, HiOut, LoOut);
        end
        tick();
        run_mul(32'h8000_0000, 32'd2, lat);
        vectors++;
        if (lat != 33 || HiOut !== 32'd1 || LoOut !== 32'd0) begin
            miscompares++;
            $display("FAIL msb_times_two: got lat=%0d HI=%h LO=%h, required lat=33 HI=1 LO=0", lat, HiOut, LoOut);
        end
        tick();
        run_mul(32'd0, 32'hFFFF_FFFF, lat);
        vectors++;
        if (lat != 33) begin
            miscompares++;
            $display("FAIL zero_latency: got %0d, required 33", lat);
        end
        for (int i = 0; i < 4; i++) begin
            a = $urandom;
            b = $urandom;
            tick();
            run_mul(a, b, lat);
            vectors++;
            if (lat != 33) begin
                miscompares++;
                $display("FAIL random_latency %0d: got %0d, required 33", i, lat);
            end
        end
    endtask

    task automatic test_ignored();
        int lat;
        tick();
        dataA = 32'h0BAD_0BAD;
        mthi  = 1'b1;
        mtlo  = 1'b1;
        tick();
        mthi = 1'b0;
        mtlo = 1'b0;
        dataA = 32'd3;
        dataB = 32'd5;
        start = 1'b1;
        exp_q.push_back(64'd15);
        tick();
        lat = -1;
        for (int k = 0; k < 40; k++) begin
            if (done === 1'b1) begin
                lat = k;
                break;
            end
            start = (k == 10);
            mthi  = (k == 5);
            dataA = (k == 5 || k == 10) ? 32'd9 : 32'd0;
            dataB = 32'd9;
            if (k == 7 || k == 20) begin
                vectors++;
                if (HiOut !== 32'h0BAD_0BAD || LoOut !== 32'h0BAD_0BAD) begin
                    miscompares++;
                    $display("FAIL busy_ignores_mthi k=%0d: got HI=%h LO=%h, required 0bad0bad both", k, HiOut, LoOut);
                end
            end
            tick();
        end
        start = 1'b0;
        mthi  = 1'b0;
        vectors++;
        if (lat != 33 || LoOut !== 32'd15 || HiOut !== 32'd0) begin
            miscompares++;
            $display("FAIL restart_ignored: got lat=%0d HI=%h LO=%h, required lat=33 HI=0 LO=15", lat, HiOut, LoOut);
        end
        tick();
        dataA = 32'd4;
        dataB = 32'd4;
        start = 1'b1;
        mtlo  = 1'b1;
        exp_q.push_back(64'd16);
        tick();
        start = 1'b0;
        mtlo  = 1'b0;
        vectors++;
        if (LoOut !== 32'd15 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL start_priority: got LO=%h busy=%b, required LO=0000000f busy=1", LoOut, busy);
        end
        for (int k = 0; k < 40 && done !== 1'b1; k++) tick();
        vectors++;
        if (done !== 1'b1 || LoOut !== 32'd16) begin
            miscompares++;
            $display("FAIL start_mtlo_result: got done=%b LO=%h, required done=1 LO=10", done, LoOut);
        end
    endtask

    task automatic test_mt();
        tick();
        dataA = 32'hDEAD_BEEF;
        mthi  = 1'b1;
        tick();
        mthi = 1'b0;
        vectors++;
        if (HiOut !== 32'hDEAD_BEEF || LoOut !== 32'd16 || done !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL mthi: got HI=%h LO=%h done=%b busy=%b, required HI=deadbeef LO=10 done=0 busy=0",
                     HiOut, LoOut, done, busy);
        end
        dataA = 32'h1234_5678;
        mthi  = 1'b1;
        mtlo  = 1'b1;
        tick();
        mthi = 1'b0;
        mtlo = 1'b0;
        vectors++;
        if (HiOut !== 32'h1234_5678 || LoOut !== 32'h1234_5678 || done !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL mthi_mtlo: got HI=%h LO=%h done=%b busy=%b, required both 12345678 done=0 busy=0",
                     HiOut, LoOut, done, busy);
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        dataA = 32'd100;
        dataB = 32'd100;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 11; k++) tick();
        reset = 1'b0;
        tick();
        vectors++;
        if (HiOut !== '0 || LoOut !== '0 || busy !== 1'b0 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid: got HI=%h LO=%h busy=%b done=%b, required all zero", HiOut, LoOut, busy, done);
        end
        reset = 1'b1;
        for (int k = 0; k < 30; k++) tick();
        run_mul(32'd2, 32'd3, lat);
        vectors++;
        if (lat != 33 || LoOut !== 32'd6 || HiOut !== 32'd0) begin
            miscompares++;
            $display("FAIL after_reset_mul: got lat=%0d HI=%h LO=%h, required lat=33 HI=0 LO=6", lat, HiOut, LoOut);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        tick();
        run_mul(32'd11, 32'd13, lat);
        vectors++;
        if (lat != 33) begin
            miscompares++;
            $display("FAIL b2b_first: got lat=%0d, required 33", lat);
        end
        run_mul(32'hCAFE_F00D, 32'h0001_0000, lat);
        vectors++;
        if (lat != 33 || HiOut !== 32'h0000_CAFE || LoOut !== 32'hF00D_0000) begin
            miscompares++;
            $display("FAIL b2b_second: got lat=%0d HI=%h LO=%h, required lat=33 HI=0000cafe LO=f00d0000",
                     lat, HiOut, LoOut);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_basic();
        test_full_width();
        test_ignored();
        test_mt();
        test_reset_mid();
        test_back_to_back();
        for (int k = 0; k < 5; k++) tick();
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: got %0d pending, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
